// File: rtl/multicycle_control_v2.sv
// Multicycle MIPS-subset control FSM with memory wait states, a mult/div
// handshake and precise exception sequencing (EPC/cause capture).
//
// Mult/div handshake: md_start is a single-cycle request pulse issued from
// MD_START, with md_op valid in the same cycle and held afterwards. The unit
// answers with a single-cycle md_done pulse. The FSM accepts md_done only
// while in MD_WAIT. If no md_done arrives within MD_MAX_CYCLES MD_WAIT
// cycles, the instruction is abandoned through the timeout exception.
module multicycle_control_v2 #(
  parameter int MEM_WAIT      = 0,
  parameter int MD_MAX_CYCLES = 34
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       div0,
  input  logic       md_done,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       mem_wr,
  output logic       reg_write,
  output logic       alu_out_write,
  output logic       epc_write,
  output logic       cause_write,
  output logic       hilo_write,
  output logic       md_start,
  output logic       md_op,
  output logic       mem_addr_src,
  output logic [1:0] pc_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] exc_cause,
  output logic [4:0] state
);

  typedef enum logic [4:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
    S_MEM_READ, S_WB_LOAD, S_MEM_WRITE, S_BRANCH, S_JUMP, S_MD_START,
    S_MD_WAIT, S_HILO_WR, S_EXC_EPC, S_EXC_JUMP
  } state_t;

  localparam logic [2:0] MW_LAST = 3'(MEM_WAIT);
  localparam logic [7:0] MD_LAST = 8'(MD_MAX_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic [7:0] md_cnt_q, md_cnt_d;
  logic       md_op_q, md_op_d;
  logic [1:0] cause_q, cause_d;

  // The zero flag only matters to the datapath's pc_write_cond gate.
  logic unused_zero;
  assign unused_zero = zero;

  // Instruction decode from the IR fields.
  logic is_r, r_add, r_sub, r_and, r_mult, r_div;
  logic i_addi, i_lw, i_sw, i_beq, i_j, wait_last;
  assign is_r      = (opcode == 6'h00);
  assign r_add     = is_r && (funct == 6'h20);
  assign r_sub     = is_r && (funct == 6'h22);
  assign r_and     = is_r && (funct == 6'h24);
  assign r_mult    = is_r && (funct == 6'h18);
  assign r_div     = is_r && (funct == 6'h1A);
  assign i_addi    = (opcode == 6'h08);
  assign i_lw      = (opcode == 6'h23);
  assign i_sw      = (opcode == 6'h2B);
  assign i_beq     = (opcode == 6'h04);
  assign i_j       = (opcode == 6'h02);
  assign wait_last = (wait_q == MW_LAST);

  // State, counters and held md_op / cause registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_RST;
      wait_q   <= '0;
      md_cnt_q <= '0;
      md_op_q  <= 1'b0;
      cause_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      md_cnt_q <= md_cnt_d;
      md_op_q  <= md_op_d;
      cause_q  <= cause_d;
    end
  end

  // Next-state and control decode; reset masks every output combinationally.
  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    md_cnt_d      = md_cnt_q;
    md_op_d       = md_op_q;
    cause_d       = cause_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    mem_wr        = 1'b0;
    reg_write     = 1'b0;
    alu_out_write = 1'b0;
    epc_write     = 1'b0;
    cause_write   = 1'b0;
    hilo_write    = 1'b0;
    md_start      = 1'b0;
    mem_addr_src  = 1'b0;
    pc_src        = 2'd0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 3'd0;
    md_op         = reset ? 1'b0 : md_op_q;
    exc_cause     = reset ? 2'd0 : cause_q;
    state         = reset ? 5'd0 : state_q;
    if (!reset) begin
      case (state_q)
        S_RST: state_d = S_FETCH;
        S_FETCH: begin
          alu_src_b = 2'd1;
          alu_op    = 3'd1;
          if (wait_last) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else begin
            wait_d = wait_q + 3'd1;
          end
        end
        S_DECODE: begin
          alu_src_b     = 2'd3;
          alu_op        = 3'd1;
          alu_out_write = 1'b1;
          if (r_add || r_sub || r_and) state_d = S_EXEC_R;
          else if (i_addi)             state_d = S_EXEC_I;
          else if (i_lw || i_sw)       state_d = S_MEM_ADDR;
          else if (i_beq)              state_d = S_BRANCH;
          else if (i_j)                state_d = S_JUMP;
          else if (r_mult || r_div) begin
            state_d = S_MD_START;
            md_op_d = r_div;
          end else begin
            state_d = S_EXC_EPC;
            cause_d = 2'd0;
          end
        end
        S_EXEC_R, S_EXEC_I: begin
          alu_src_a     = 1'b1;
          alu_out_write = 1'b1;
          if (state_q == S_EXEC_R) begin
            alu_src_b = 2'd0;
            alu_op    = r_sub ? 3'd2 : (r_and ? 3'd3 : 3'd1);
          end else begin
            alu_src_b = 2'd2;
            alu_op    = 3'd1;
          end
          // Logical AND never traps on overflow.
          if (overflow && !r_and) begin
            state_d = S_EXC_EPC;
            cause_d = 2'd1;
          end else begin
            state_d = S_WB_ALU;
          end
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
          reg_dst   = is_r;
          state_d   = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src_a     = 1'b1;
          alu_src_b     = 2'd2;
          alu_op        = 3'd1;
          alu_out_write = 1'b1;
          state_d       = i_lw ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          mem_addr_src = 1'b1;
          if (wait_last) begin
            mdr_write = 1'b1;
            state_d   = S_WB_LOAD;
          end else begin
            wait_d = wait_q + 3'd1;
          end
        end
        S_WB_LOAD: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEM_WRITE: begin
          mem_addr_src = 1'b1;
          mem_wr       = 1'b1;
          state_d      = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 3'd2;
          pc_write_cond = 1'b1;
          pc_src        = 2'd1;
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
          state_d  = S_FETCH;
        end
        S_MD_START: begin
          md_op_d = r_div;
          if (r_div && div0) begin
            state_d = S_EXC_EPC;
            cause_d = 2'd2;
          end else begin
            md_start = 1'b1;
            md_cnt_d = '0;
            state_d  = S_MD_WAIT;
          end
        end
        S_MD_WAIT: begin
          md_cnt_d = md_cnt_q + 8'd1;
          // A result arriving on the final allowed cycle still completes.
          if (md_done) begin
            state_d = S_HILO_WR;
          end else if (md_cnt_q == MD_LAST) begin
            state_d = S_EXC_EPC;
            cause_d = 2'd3;
          end
        end
        S_HILO_WR: begin
          hilo_write = 1'b1;
          state_d    = S_FETCH;
        end
        S_EXC_EPC: begin
          alu_src_b   = 2'd1;
          alu_op      = 3'd2;
          epc_write   = 1'b1;
          cause_write = 1'b1;
          state_d     = S_EXC_JUMP;
        end
        S_EXC_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'd3;
          state_d  = S_FETCH;
        end
        default: state_d = S_RST;
      endcase
    end
  end

endmodule
